alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_sequencer_rr_arb2.sv | 19 +
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and ALU mode encodings for the ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EXEC       = 2'd1,
        SHIFT_WAIT = 2'd2,
        RESP       = 2'd3
    } state_t;

    localparam logic [2:0] MODE_ADD = 3'd0;
    localparam logic [2:0] MODE_SUB = 3'd1;
    localparam logic [2:0] MODE_AND = 3'd2;
    localparam logic [2:0] MODE_OR  = 3'd3;
    localparam logic [2:0] MODE_XOR = 3'd4;
    localparam logic [2:0] MODE_SLT = 3'd5;
    localparam logic [2:0] MODE_SLL = 3'd6;
    localparam logic [2:0] MODE_SRL = 3'd7;

    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SLL) || (mode == MODE_SRL);
    endfunction

endpackage

// File: rtl/alu_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences operations from two requesters onto a shared external ALU.
// Define ALU_SEQ_SHIFT_TIMEOUT_EN to bound the wait for shift completion.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [5:0]            req_mode,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [2:0]            alu_mode,
    output logic                  alu_start_shift,
    input  logic [DATA_W-1:0]     alu_answer,
    input  logic                  alu_zero,
    input  logic                  alu_done_shift,
    output logic                  busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state_q;
    logic [DATA_W-1:0]   a_q, b_q, rsp_data_q;
    logic [2:0]          mode_q;
    logic                owner_q;
    logic                rr_ptr_q;  // requester favoured on the next tie
    logic                start_q;
    logic                rsp_zero_q;
    logic [1:0]          rsp_valid_q;

    logic [1:0]          grant;
    logic                sel_d;
    logic [DATA_W-1:0]   sel_a_d, sel_b_d;
    logic [2:0]          sel_mode_d;
    logic [1:0]          owner_oh;

`ifdef ALU_SEQ_SHIFT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
`endif

    rr_arb2 u_arb (
        .req_i   (req_valid),
        .last_i  (~rr_ptr_q),
        .grant_o (grant)
    );

    assign sel_d      = grant[1];
    assign sel_a_d    = sel_d ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
    assign sel_b_d    = sel_d ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
    assign sel_mode_d = sel_d ? req_mode[5:3] : req_mode[2:0];
    assign owner_oh   = owner_q ? 2'b10 : 2'b01;

    assign req_ready       = (state_q == IDLE) ? grant : 2'b00;
    assign busy            = (state_q != IDLE);
    assign alu_a           = a_q;
    assign alu_b           = b_q;
    assign alu_mode        = mode_q;
    assign alu_start_shift = start_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_zero        = rsp_zero_q;
`ifdef ALU_SEQ_SHIFT_TIMEOUT_EN
    assign rsp_err         = err_q;
`else
    assign rsp_err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
`ifdef ALU_SEQ_SHIFT_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        a_q      <= sel_a_d;
                        b_q      <= sel_b_d;
                        mode_q   <= sel_mode_d;
                        owner_q  <= sel_d;
                        rr_ptr_q <= grant[0];
                        start_q  <= is_shift(sel_mode_d);
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    start_q <= 1'b0;
                    if (is_shift(mode_q)) begin
`ifdef ALU_SEQ_SHIFT_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                        state_q <= SHIFT_WAIT;
                    end else begin
                        rsp_data_q  <= alu_answer;
                        rsp_zero_q  <= alu_zero;
`ifdef ALU_SEQ_SHIFT_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                        rsp_valid_q <= owner_oh;
                        state_q     <= RESP;
                    end
                end
                SHIFT_WAIT: begin
                    if (alu_done_shift) begin
                        rsp_data_q  <= alu_answer;
                        rsp_zero_q  <= alu_zero;
`ifdef ALU_SEQ_SHIFT_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                        rsp_valid_q <= owner_oh;
                        state_q     <= RESP;
                    end
`ifdef ALU_SEQ_SHIFT_TIMEOUT_EN
                    // Last waiting cycle without completion: give up with an error.
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_zero_q  <= 1'b0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= owner_oh;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus randomized
// operations against a behavioural ALU/arbiter model.
module tb_alu_sequencer;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a = '0, req_b = '0;
    logic [5:0]     req_mode = '0;
    logic [1:0]     rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_zero, rsp_err;
    logic [W-1:0]   alu_a, alu_b;
    logic [2:0]     alu_mode;
    logic           alu_start_shift;
    logic [W-1:0]   alu_answer;
    logic           alu_zero, alu_done_shift;
    logic           busy;

    int n_chk  = 0;
    int n_fail = 0;
    int shift_lat = 0;
    int shift_cnt = 0;

    alu_sequencer #(.DATA_W(W), .TIMEOUT_CYCLES(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_start_shift(alu_start_shift),
        .alu_answer(alu_answer), .alu_zero(alu_zero), .alu_done_shift(alu_done_shift),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] m);
        logic [W-1:0] r;
        case (m)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'd6: r = a << b[3:0];
            default: r = a >> b[3:0];
        endcase
        return r;
    endfunction

    // External ALU model: shifts finish shift_lat cycles after the start pulse
    // (never when shift_lat is 0); the answer is junk until then.
    always @(posedge clk or posedge reset) begin
        if (reset)                shift_cnt <= 0;
        else if (alu_start_shift) shift_cnt <= shift_lat;
        else if (shift_cnt > 0)   shift_cnt <= shift_cnt - 1;
    end
    assign alu_done_shift = (shift_cnt == 1);
    always_comb begin
        if ((alu_mode == 3'd6 || alu_mode == 3'd7) && !alu_done_shift) alu_answer = 16'hDEAD;
        else alu_answer = ref_alu(alu_a, alu_b, alu_mode);
    end
    assign alu_zero = (alu_answer == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one operation from requester id and check it end to end.
    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] mode, input int lat, input bit hold_other);
        logic [W-1:0] exp_d;
        bit got, seen, bad_ready, bad_start;
        int n;
        exp_d = ref_alu(a, b, mode);
        shift_lat = lat;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_mode[id*3 +: 3] = mode;
        req_valid[id] = 1'b1;
        #1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready[id]) begin got = 1; break; end
            @(negedge clk); #1;
        end
        chk("handshake", 32'(got), 32'd1);
        chk("ready_onehot", 32'(req_ready), 32'(2'b01 << id));
        @(negedge clk);
        req_valid[id] = 1'b0;
        if (hold_other) req_valid[1-id] = 1'b1;
        #1;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_alu_a", 32'(alu_a), 32'(a));
        chk("exec_alu_b", 32'(alu_b), 32'(b));
        chk("exec_alu_mode", 32'(alu_mode), 32'(mode));
        chk("exec_start", 32'(alu_start_shift), 32'(mode >= 3'd6));
        if (mode >= 3'd6) begin
            n = 0; seen = 0; bad_ready = 0; bad_start = 0;
            for (int i = 0; i < 64; i++) begin
                @(negedge clk); #1;
                if (rsp_valid != 2'b00) begin seen = 1; break; end
                if (req_ready != 2'b00) bad_ready = 1;
                if (alu_start_shift) bad_start = 1;
                n++;
            end
            chk("shift_rsp_seen", 32'(seen), 32'd1);
            chk("shift_wait_cycles", 32'(n), 32'(lat));
            chk("shift_ready_low", 32'(bad_ready), 32'd0);
            chk("shift_start_pulse", 32'(bad_start), 32'd0);
        end else begin
            @(negedge clk); #1;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << id));
        chk("rsp_data", 32'(rsp_data), 32'(exp_d));
        chk("rsp_zero", 32'(rsp_zero), 32'(exp_d == '0));
        chk("rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk); #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_rsp_hold", 32'(rsp_data), 32'(exp_d));
        chk("post_ready", 32'(req_ready), hold_other ? 32'(2'b01 << (1-id)) : 32'd0);
        req_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants, exp_next, ctn_owner;
        bit bad;
        // Reset state
        @(negedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_mode", 32'(alu_mode), 32'd0);
        chk("rst_start", 32'(alu_start_shift), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed: add, subtract to zero, shift with blocked second requester
        run_op(0, 16'h0003, 16'h0004, 3'd0, 0, 1'b0);
        run_op(1, 16'h0005, 16'h0005, 3'd1, 0, 1'b0);
        run_op(0, 16'h0001, 16'h0004, 3'd6, 4, 1'b1);

        // Contention from reset: grants alternate 0,1,0,1
        do_reset();
        req_a = {16'h0020, 16'h0010};
        req_b = {16'h0002, 16'h0001};
        req_mode = {3'd1, 3'd0};
        req_valid = 2'b11;
        grants = 0; exp_next = 0; ctn_owner = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (!busy) begin
                chk("ctn_grant", 32'(req_ready), 32'(2'b01 << exp_next));
                ctn_owner = exp_next;
                exp_next ^= 1;
                grants++;
            end else begin
                chk("ctn_ready_busy", 32'(req_ready), 32'd0);
                if (rsp_valid != 2'b00) begin
                    chk("ctn_rsp_owner", 32'(rsp_valid), 32'(2'b01 << ctn_owner));
                    chk("ctn_rsp_data", 32'(rsp_data),
                        32'(ctn_owner == 0 ? 16'h0011 : 16'h001E));
                end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("ctn_grant_count", 32'(grants), 32'd4);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            logic [2:0] rm;
            ra = W'($urandom);
            rm = 3'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_op($urandom_range(0, 1), ra, rb, rm, $urandom_range(1, 6),
                   1'($urandom_range(0, 1)));
        end

        // Reset during SHIFT_WAIT drops the operation and re-arms the pointer
        shift_lat = 0;
        req_a[0 +: W] = 16'h1234;
        req_mode = {3'd0, 3'd6};
        req_valid = 2'b01;
        #1;
        chk("rst_sw_handshake", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sw_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_sw_busy", 32'(busy), 32'd0);
        chk("rst_sw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sw_start", 32'(alu_start_shift), 32'd0);
        chk("rst_sw_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (rsp_valid != 2'b00 || busy) bad = 1;
        end
        chk("rst_sw_no_rsp", 32'(bad), 32'd0);
        req_mode = {3'd0, 3'd0};
        req_valid = 2'b11;
        #1;
        chk("rst_sw_tie_to_0", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        @(negedge clk);

`ifdef ALU_SEQ_SHIFT_TIMEOUT_EN
        begin
            int n;
            shift_lat = 0;
            req_a[W +: W] = 16'h00FF;
            req_b[W +: W] = 16'h0001;
            req_mode = {3'd7, 3'd0};
            req_valid = 2'b10;
            #1;
            chk("to_handshake", 32'(req_ready), 32'h2);
            @(negedge clk);
            req_valid = 2'b00;
            n = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk); #1;
                if (rsp_valid != 2'b00) break;
                n++;
            end
            chk("to_wait_cycles", 32'(n), 32'd32);
            chk("to_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("to_rsp_err", 32'(rsp_err), 32'd1);
            chk("to_rsp_data", 32'(rsp_data), 32'd0);
            chk("to_rsp_zero", 32'(rsp_zero), 32'd0);
            @(negedge clk);
            run_op(1, 16'h0080, 16'h0003, 3'd7, 3, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
